// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the async FIFO (destination clock domain).
// Decodes the synchronized Gray write pointer, issues RAM reads, feeds a
// two-slot (head + skid) first-word-fall-through valid/ready stream, and
// returns a registered Gray read pointer to the write domain.
module fifo_rd_ctrl #(
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH:0]   wptr_gray_sync,
  output logic [ADDR_WIDTH:0]   rptr_gray,
  output logic                  mem_ren,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  rd_empty,
  output logic [ADDR_WIDTH:0]   rd_level,
  output logic                  err_overflow
);

  localparam int unsigned PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] DEPTH = PW'(1 << ADDR_WIDTH);

  logic [PW-1:0]         wbin;
  logic [PW-1:0]         rbin_q, rbin_d;
  logic [PW-1:0]         rptr_gray_q, rptr_gray_d;
  logic                  m_valid_q, m_valid_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic                  skid_v_q, skid_v_d;
  logic [DATA_WIDTH-1:0] skid_q, skid_d;
  logic                  infl_q;
  logic                  err_q, err_d;
  logic                  fifo_empty;
  logic                  pop;
  logic [1:0]            occ;
  logic                  room;

  // Gray-to-binary decode: each binary bit is the XOR of all Gray bits at or above it
  always_comb begin
    wbin = '0;
    for (int unsigned i = 0; i < PW; i++) begin
      wbin[i] = ^(wptr_gray_sync >> i);
    end
  end

  // Pointer comparison, occupancy of the read path and the read-issue decision
  always_comb begin
    fifo_empty = (wbin == rbin_q);
    rd_level   = wbin - rbin_q;
    pop        = m_valid_q & m_ready;
    occ        = {1'b0, m_valid_q} + {1'b0, skid_v_q} + {1'b0, infl_q};
    // Words already held or in flight, minus the one leaving this cycle, must leave a free slot
    room       = (occ - {1'b0, pop}) < 2'd2;
    mem_ren    = !rst && !fifo_empty && room;
    mem_raddr  = rbin_q[ADDR_WIDTH-1:0];
    rbin_d     = rbin_q + {{ADDR_WIDTH{1'b0}}, mem_ren};
    rptr_gray_d = rbin_d ^ (rbin_d >> 1);
    err_d      = err_q | (rd_level > DEPTH);
  end

  // Head/skid routing: pop is applied first, then the returning RAM word lands in the
  // head if that slot is (or just became) free with no older word in skid, else in skid
  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    skid_v_d  = skid_v_q;
    skid_d    = skid_q;
    if (pop) begin
      if (skid_v_q) begin
        m_data_d = skid_q;
        skid_v_d = 1'b0;
      end else begin
        m_valid_d = 1'b0;
      end
    end
    if (infl_q) begin
      if ((!m_valid_q || pop) && !skid_v_q) begin
        m_data_d  = mem_rdata;
        m_valid_d = 1'b1;
      end else begin
        skid_d   = mem_rdata;
        skid_v_d = 1'b1;
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      rbin_q      <= '0;
      rptr_gray_q <= '0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      skid_v_q    <= 1'b0;
      skid_q      <= '0;
      infl_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      rbin_q      <= rbin_d;
      rptr_gray_q <= rptr_gray_d;
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      skid_v_q    <= skid_v_d;
      skid_q      <= skid_d;
      infl_q      <= mem_ren;
      err_q       <= err_d;
    end
  end

  assign rptr_gray    = rptr_gray_q;
  assign m_valid      = m_valid_q;
  assign m_data       = m_data_q;
  assign err_overflow = err_q;
  assign rd_empty     = fifo_empty & !m_valid_q & !skid_v_q & !infl_q;

endmodule
